if_id_stage: RTL
================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter CNT_W, default 32, width of the performance counters.
REQ-003 Clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Reset  in  1  asynchronous, active-high reset.
REQ-005 Hazard  in  1  load-use stall request from decode; 1 = hold PC and IF/ID.
REQ-006 Flush  in  2  redirect request from the controller; nonzero = redirect this cycle, 0 = none.
REQ-007 Branch  in  1  1 = the redirect is a taken branch.
REQ-008 cntrljr  in  2  jump select: 0 = jr, 1 = j/jal, 2 = sequential.
REQ-009 BranchTarget, JumpTarget, JrTarget  in  32 each  candidate redirect addresses.
REQ-010 IMemData  in  32  instruction word, combinational read at IMemAddr.
REQ-011 IMemAddr  out  32  current PC driven to instruction memory.
REQ-012 Instr_ID  out  32  registered instruction presented to decode/controller.
REQ-013 PCPlus4_ID  out  32  registered PC+4 of Instr_ID.
REQ-014 Valid_ID  out  1  1 = Instr_ID is a real fetched instruction; 0 = bubble.
REQ-015 FetchCnt, SquashCnt, StallCnt  out  CNT_W each  performance counters.

Function
REQ-016 Per-cycle priority SHALL be: Reset > redirect (Flush!=0) > stall (Hazard=1) > normal fetch.
REQ-017 Normal fetch: PC <= PC+4; Instr_ID <= IMemData; PCPlus4_ID <= PC+4; Valid_ID <= 1.
REQ-018 Stall: PC, Instr_ID, PCPlus4_ID and Valid_ID SHALL hold their values.
REQ-019 Redirect target SHALL be BranchTarget if Branch=1, else JrTarget if cntrljr=0, else JumpTarget if cntrljr=1, else PC+4.
REQ-020 Redirect: PC <= target; Instr_ID <= 32'h0000_0000 (sll $0 NOP); PCPlus4_ID <= 0; Valid_ID <= 0; latency is one cycle (the target is on IMemAddr in the cycle after Flush).
REQ-021 Redirect and Hazard in the same cycle: redirect SHALL win, and the stall SHALL be dropped.
REQ-022 A redirect pending flag SHALL be set when Flush!=0 and Hazard=1 arrive together. For one cycle after that, a Hazard-only stall SHALL still load Instr_ID with the bubble, so that no stale instruction is replayed.
REQ-023 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); PC bits [1:0] SHALL always be 0 (target bits [1:0] are forced to 0).
REQ-024 FetchCnt SHALL increment on each normal-fetch cycle.
REQ-025 SquashCnt SHALL increment on each redirect cycle in which Valid_ID was 1.
REQ-026 StallCnt SHALL increment on each stall cycle.
REQ-027 All counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-028 The fetch FSM SHALL have three states: RUN, STALL, REDIRECT.
  - RUN -> STALL on Hazard.
  - any -> REDIRECT on Flush!=0.
  - STALL -> RUN when Hazard drops.
  - REDIRECT -> RUN after one cycle, or -> STALL if Hazard=1 and Flush=0.

Reset
REQ-029 Reset assertion SHALL asynchronously force:
  - PC = RESET_PC; Instr_ID = 0; PCPlus4_ID = 0; Valid_ID = 0;
  - all counters = 0; pending flag = 0; FSM = RUN.
REQ-030 Reset asserted mid-stall or mid-redirect SHALL discard the pending redirect. The first fetch after deassertion SHALL be from RESET_PC.

Structure
REQ-031 A shared package SHALL hold:
  - cntrljr encodings (JR=0, JUMP=1, SEQ=2);
  - NOP_INSTR = 32'h0;
  - FSM state encodings;
  - RESET_PC default.
REQ-032 The block SHALL contain one sub-module, sat_counter (CNT_W wide, inc/clear, saturating), instantiated three times.

Verification
REQ-033 Reset, then 4 cycles free-running with RESET_PC=0 -> IMemAddr 0,4,8,12; FetchCnt=4; Valid_ID=1 from cycle 2.
REQ-034 Hazard=1 for 2 cycles at PC=8 -> IMemAddr stays 8; Instr_ID unchanged; StallCnt=2; fetch resumes at 12.
REQ-035 Flush=1, Branch=1, BranchTarget=0x40 -> next IMemAddr=0x40; Instr_ID=0; Valid_ID=0; SquashCnt+1.
REQ-036 Flush=1, cntrljr=0, JrTarget=0x103 together with Hazard=1 -> IMemAddr=0x100; next Hazard-only cycle keeps Valid_ID=0.
REQ-037 PC forced to 0xFFFFFFFC by jump, then 1 free-running cycle -> IMemAddr=0x0; PCPlus4_ID=0x0.
REQ-038 Reset pulse mid-stall with CNT_W=4 and FetchCnt saturated at 15 -> all outputs at reset values; a further 20 fetches leave FetchCnt at 15.

Source files
------------

// File: rtl/if_id_stage_pkg.sv
// Shared types and constants for the IF/ID pipeline stage.
// Holds the jump-select encodings, the NOP bubble word, the fetch FSM states and the default reset PC.
package if_id_stage_pkg;

  typedef enum logic [1:0] {
    CjJr   = 2'd0,
    CjJump = 2'd1,
    CjSeq  = 2'd2
  } cntrljr_e;

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StStall    = 2'd1,
    StRedirect = 2'd2
  } fetch_state_e;

  // sll $0,$0,0 encodes as all zeros
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_id_stage_if.sv
// Bundle of the fetch-stage control inputs, instruction-memory link and IF/ID outputs.
// The master drives control and memory data; the slave is the fetch stage itself.
interface if_id_stage_if #(
  parameter int unsigned CNT_W = 32
);
  logic             hazard;
  logic [1:0]       flush;
  logic             branch;
  logic [1:0]       cntrljr;
  logic [31:0]      branch_target;
  logic [31:0]      jump_target;
  logic [31:0]      jr_target;
  logic [31:0]      imem_data;
  logic [31:0]      imem_addr;
  logic [31:0]      instr_id;
  logic [31:0]      pcplus4_id;
  logic             valid_id;
  logic [CNT_W-1:0] fetch_cnt;
  logic [CNT_W-1:0] squash_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output hazard, flush, branch, cntrljr, branch_target, jump_target, jr_target, imem_data,
    input  imem_addr, instr_id, pcplus4_id, valid_id, fetch_cnt, squash_cnt, stall_cnt
  );

  modport slave (
    input  hazard, flush, branch, cntrljr, branch_target, jump_target, jr_target, imem_data,
    output imem_addr, instr_id, pcplus4_id, valid_id, fetch_cnt, squash_cnt, stall_cnt
  );
endinterface

// File: rtl/if_id_stage_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch stage and IF/ID pipeline register with redirect, load-use stall and
// saturating performance counters. Priority: reset > redirect > stall > fetch.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned CNT_W    = 32
) (
  input logic          clk,
  input logic          rst,
  if_id_stage_if.slave bus
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic [31:0]  pcplus4_q;
  logic         valid_q;
  logic         pending_q;

  logic         redirect;
  logic         stall_req;
  logic         fetch;
  logic [31:0]  pc_plus4;
  logic [31:0]  target;

  assign pc_plus4  = pc_q + 32'd4;
  assign redirect  = (bus.flush != 2'b00);
  assign stall_req = !redirect && bus.hazard;
  assign fetch     = !redirect && !bus.hazard;

  always_comb begin
    target = pc_plus4;
    if (bus.branch) begin
      target = bus.branch_target;
    end else if (bus.cntrljr == CjJr) begin
      target = bus.jr_target;
    end else if (bus.cntrljr == CjJump) begin
      target = bus.jump_target;
    end
    target[1:0] = 2'b00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StRun;
      pc_q      <= {RESET_PC[31:2], 2'b00};
      instr_q   <= NOP_INSTR;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      // Remembers a redirect that swallowed a simultaneous stall request
      pending_q <= redirect && bus.hazard;
      if (redirect) begin
        state_q   <= StRedirect;
        pc_q      <= target;
        instr_q   <= NOP_INSTR;
        pcplus4_q <= '0;
        valid_q   <= 1'b0;
      end else if (bus.hazard) begin
        state_q <= StStall;
        // Right after such a redirect, keep a bubble instead of replaying a stale word
        if (pending_q && (state_q == StRedirect)) begin
          instr_q   <= NOP_INSTR;
          pcplus4_q <= '0;
          valid_q   <= 1'b0;
        end
      end else begin
        state_q   <= StRun;
        pc_q      <= pc_plus4;
        instr_q   <= bus.imem_data;
        pcplus4_q <= pc_plus4;
        valid_q   <= 1'b1;
      end
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.instr_id   = instr_q;
  assign bus.pcplus4_id = pcplus4_q;
  assign bus.valid_id   = valid_q;

  sat_counter #(.CNT_W(CNT_W)) u_fetch_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (1'b0),
    .inc  (fetch),
    .count(bus.fetch_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_squash_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (1'b0),
    .inc  (redirect && valid_q),
    .count(bus.squash_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (1'b0),
    .inc  (stall_req),
    .count(bus.stall_cnt)
  );

endmodule
